// File: rtl/top_register_pkg.sv
// Shared constants for the parameterised D-type register bank.
package top_register_pkg;

  // Default number of stored bits when the parameter is not overridden.
  localparam int unsigned REG_WIDTH_DEFAULT = 4;

  // Maximum supported width; the reset constant is sized to cover it.
  localparam int unsigned REG_WIDTH_MAX = 64;

  // Reset / power-up value, zero-extended to any legal width.
  localparam logic [REG_WIDTH_MAX-1:0] REG_RESET_VALUE = '0;

endpackage : top_register_pkg

// File: rtl/top_register_dff_bit.sv
// Single-bit positive-edge D flip-flop with synchronous active-high reset.
// The storage element starts at its reset value at time zero,
// so no reset pulse is needed after power-up.
module dff_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  // Power-up value comes from the register initialiser.
  logic q_reg = RESET_VAL;

  // Capture D on every rising edge; reset wins over data on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= RESET_VAL;
    end else begin
      q_reg <= D;
    end
  end

  assign Q = q_reg;

endmodule : dff_bit

// File: rtl/top_register.sv
// Parameterised positive-edge D-type register built from WIDTH
// independent single-bit flip-flops. No combinational D-to-Q path.
module top_register
  import top_register_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             RST
);

  // One flip-flop per bit; each bit sees only its own D, the shared RST and CLK.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    dff_bit #(
      .RESET_VAL (REG_RESET_VALUE[gi])
    ) u_dff_bit (
      .CLK (CLK),
      .RST (RST),
      .D   (D[gi]),
      .Q   (Q[gi])
    );
  end

endmodule : top_register

// File: tb/tb_top_register.sv
// Self-checking bench for top_register at WIDTH = 4, 1 and 32.
// Directed scenarios followed by randomized cycles; the expected value of
// each register is derived from the applied D/RST using the capture rules.
module tb_top_register;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  d4  = '0;
  logic        d1  = '0;
  logic [31:0] d32 = '0;
  logic [3:0]  q4;
  logic        q1;
  logic [31:0] q32;

  int tests = 0;
  int fails = 0;

  // Expected register contents (behavioural model).
  logic [3:0]  exp4  = '0;
  logic        exp1  = '0;
  logic [31:0] exp32 = '0;

  // 10 ns period, first rising edge at 5 ns.
  always #5 CLK = ~CLK;

  top_register #(.WIDTH(4)) u_dut4 (
    .CLK (CLK), .D (d4), .Q (q4), .RST (RST)
  );
  top_register #(.WIDTH(1)) u_dut1 (
    .CLK (CLK), .D (d1), .Q (q1), .RST (RST)
  );
  top_register #(.WIDTH(32)) u_dut32 (
    .CLK (CLK), .D (d32), .Q (q32), .RST (RST)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_value({tag, "/w4"},  {60'd0, q4},  {60'd0, exp4});
    check_value({tag, "/w1"},  {63'd0, q1},  {63'd0, exp1});
    check_value({tag, "/w32"}, {32'd0, q32}, {32'd0, exp32});
  endtask

  // Apply D/RST on a falling edge, confirm Q holds until the rising edge,
  // confirm the new value after it, then glitch D during the high phase.
  task automatic run_cycle(input logic [31:0] dval, input logic rst, input string tag);
    @(negedge CLK);
    d4  = dval[3:0];
    d1  = dval[0];
    d32 = dval;
    RST = rst;
    #2;
    check_all({tag, "/hold"});
    @(posedge CLK);
    // Reset clears; otherwise each width keeps the low bits of the value.
    exp4  = rst ? 4'd0  : dval[3:0];
    exp1  = rst ? 1'b0  : dval[0];
    exp32 = rst ? 32'd0 : dval;
    #1;
    check_all({tag, "/load"});
    d4  = 4'($urandom);
    d1  = 1'($urandom);
    d32 = $urandom;
    #2;
    check_all({tag, "/glitch"});
    $display("[TB] cycle %s d=%08h rst=%0b q4=%h q1=%b q32=%08h", tag, dval, rst, q4, q1, q32);
  endtask

  // Reset pulse fully inside the low phase must leave Q untouched.
  task automatic short_reset_pulse();
    @(negedge CLK);
    d4  = exp4;
    d1  = exp1;
    d32 = exp32;
    #1 RST = 1'b1;
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    check_all("short_rst");
    $display("[TB] short reset pulse q4=%h q1=%b q32=%08h", q4, q1, q32);
  endtask

  initial begin
    logic [31:0] rval;
    logic        rrst;

    // Power-up: no edge yet, no reset asserted.
    #1;
    check_all("powerup");
    $display("[TB] powerup q4=%h q1=%b q32=%08h", q4, q1, q32);

    // Capture and sequence.
    run_cycle(32'h0000_0001, 1'b0, "capture");
    run_cycle(32'h0000_000A, 1'b0, "seq_1010");
    run_cycle(32'h0000_0005, 1'b0, "seq_0101");
    run_cycle(32'hFFFF_FFFF, 1'b0, "seq_ones");

    // Synchronous reset from all-ones, then release with new data.
    run_cycle(32'hFFFF_FFFF, 1'b1, "sync_rst");
    run_cycle(32'h0000_0006, 1'b0, "rst_release");

    // Reset priority over data on the same edge.
    run_cycle(32'h0000_0009, 1'b1, "rst_priority");

    // Short reset pulse between edges.
    run_cycle(32'hFFFF_FFFF, 1'b0, "reload_ones");
    short_reset_pulse();

    // Width scaling patterns.
    run_cycle(32'hFFFF_FFFF, 1'b0, "all_ones");
    run_cycle(32'hAAAA_AAAA, 1'b0, "alt_aa");
    run_cycle(32'h5555_5555, 1'b0, "alt_55");
    run_cycle(32'hAAAA_AAAA, 1'b1, "alt_rst");

    // Randomized cycles with occasional reset.
    for (int i = 0; i < 40; i++) begin
      rval = $urandom;
      rrst = ($urandom_range(0, 7) == 0);
      run_cycle(rval, rrst, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_top_register
